// File: rtl/eth_port_tx.sv
// Port-side Ethernet frame transmitter: a payload FIFO feeding a framing FSM that emits
// PREAMBLE, {dst,src}, length, payload and an XOR checksum word, then an idle gap.
module eth_port_tx #(
    parameter int unsigned  DEPTH    = 16,
    parameter int unsigned  IFG      = 2,
    parameter logic [31:0]  PREAMBLE = 32'h5555_55D5,
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned CW       = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pl_valid,
    output logic          pl_ready,
    input  logic [31:0]   pl_data,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [15:0]   cmd_dst,
    input  logic [15:0]   cmd_src,
    input  logic [CW-1:0] cmd_len,
    output logic [31:0]   dataOut,
    output logic          tx_sop,
    output logic          tx_eop,
    output logic          tx_busy,
    output logic          tx_err,
    output logic [CW-1:0] fifo_count
);

    localparam int unsigned GW = $clog2(IFG + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_LEN,
        S_PAY,
        S_FCS,
        S_GAP
    } state_e;

    state_e        state_q, state_d;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    logic [15:0]   dst_q, src_q;
    logic [CW-1:0] len_q;
    logic [CW-1:0] beat_q, beat_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [31:0]   fcs_q, fcs_d;

    logic [31:0]   data_q, data_d;
    logic          sop_q, sop_d;
    logic          eop_q, eop_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    logic          cmd_legal, cmd_fire, cmd_accept;

    // ------------------------------------------------------------------
    // Payload FIFO
    // ------------------------------------------------------------------
    assign pl_ready = (count_q != CW'(DEPTH));
    assign push     = pl_valid && pl_ready;
    assign pop      = (state_q == S_PAY);

    // NOTE: every variable assigned in an always_comb gets a default first, so no path
    // can leave it holding its old value and infer a latch.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: the storage array is deliberately not reset; the count and pointers alone
    // decide which entries are valid, and a reset-free array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= pl_data;
        end
    end

    // NOTE: sequential state is always updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Command handshake: illegal commands are always taken so they cannot wedge IDLE
    // ------------------------------------------------------------------
    assign cmd_legal  = (cmd_len != '0) && (cmd_len <= CW'(DEPTH));
    assign cmd_ready  = (state_q == S_IDLE) && (!cmd_legal || (count_q >= cmd_len));
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign cmd_accept = cmd_fire && cmd_legal;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            gap_q   <= '0;
            dst_q   <= '0;
            src_q   <= '0;
            len_q   <= '0;
            fcs_q   <= '0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            fcs_q   <= fcs_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            if (cmd_accept) begin
                dst_q <= cmd_dst;
                src_q <= cmd_src;
                len_q <= cmd_len;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: if (cmd_accept) state_d = S_PRE;
            S_PRE:  state_d = S_HDR;
            S_HDR:  state_d = S_LEN;
            S_LEN: begin
                state_d = S_PAY;
                beat_d  = len_q;
            end
            S_PAY: begin
                beat_d = beat_q - CW'(1);
                if (beat_q == CW'(1)) state_d = S_FCS;
            end
            S_FCS: begin
                state_d = S_GAP;
                gap_d   = GW'(IFG - 1);
            end
            S_GAP: begin
                if (gap_q == '0) state_d = S_IDLE;
                else             gap_d   = gap_q - GW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (registered one cycle behind the state that produces it)
    // ------------------------------------------------------------------
    always_comb begin
        data_d = '0;
        fcs_d  = fcs_q;
        case (state_q)
            S_IDLE: if (cmd_accept) fcs_d = '0;
            S_PRE:  data_d = PREAMBLE;
            S_HDR: begin
                data_d = {dst_q, src_q};
                fcs_d  = fcs_q ^ data_d;
            end
            S_LEN: begin
                data_d = {{(16 - CW){1'b0}}, len_q, 16'h0000};
                fcs_d  = fcs_q ^ data_d;
            end
            S_PAY: begin
                data_d = mem[rd_ptr_q];
                fcs_d  = fcs_q ^ data_d;
            end
            S_FCS:   data_d = fcs_q;
            default: data_d = '0;
        endcase
        sop_d  = (state_q == S_PRE);
        eop_d  = (state_q == S_FCS);
        busy_d = (state_d != S_IDLE);
        err_d  = cmd_fire && !cmd_legal;
    end

    assign dataOut    = data_q;
    assign tx_sop     = sop_q;
    assign tx_eop     = eop_q;
    assign tx_busy    = busy_q;
    assign tx_err     = err_q;
    assign fifo_count = count_q;

endmodule

// File: doc/eth_port_tx.md
# eth_port_tx

Port-side frame transmitter for the 32-bit Ethernet switch. It buffers payload words from an upstream source, accepts a per-frame command (destination, source, length), and serialises a complete frame onto a 32-bit word stream. That stream drives a switch input port (dataIn_A or dataIn_B). It is the sending counterpart to the switch's ingress logic and is used both in RTL integration and as the bench's reference stimulus generator.

## Interface

- DEPTH, 16, payload FIFO depth in words; also the maximum legal frame length. Must be a power of two, ≥ 2.
- IFG, 2, idle (gap) cycles inserted after each frame's FCS word; ≥ 1.
- PREAMBLE, 32'h5555_55D5, start-of-frame delimiter word.

Ports:

- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; asserting it clears all state immediately.
- pl_valid  in  1  payload word valid.
- pl_ready  out  1  FIFO can accept a word (= !full).
- pl_data  in  32  payload word.
- cmd_valid  in  1  frame command valid.
- cmd_ready  out  1  command accepted this cycle when high with cmd_valid.
- cmd_dst  in  16  destination address.
- cmd_src  in  16  source address.
- cmd_len  in  $clog2(DEPTH)+1  payload length in words.
- dataOut  out  32  transmitted word stream, to the switch dataIn port.
- tx_sop  out  1  high on the cycle dataOut carries PREAMBLE.
- tx_eop  out  1  high on the cycle dataOut carries FCS.
- tx_busy  out  1  high in every state except IDLE.
- tx_err  out  1  one-cycle pulse when an illegal command is dropped.
- fifo_count  out  $clog2(DEPTH)+1  words currently buffered.

## Operation

- Payload FIFO:
  - Push on pl_valid && pl_ready.
  - Pop one word per cycle in PAY only.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
  - pl_ready is low when count == DEPTH; writes while full are impossible by handshake.
- Command legality: 1 ≤ cmd_len ≤ DEPTH.
- cmd_ready is high only in IDLE, and then only when either:
  - the command is legal and fifo_count ≥ cmd_len, or
  - the command is illegal.
- An illegal command is consumed, pulses tx_err the next cycle, and stays in IDLE. No frame is sent and the FIFO is untouched.
- On legal acceptance, the block latches dst/src/len and clears the FCS accumulator.
- FSM states: IDLE → PRE → HDR → LEN → PAY (len cycles) → FCS → GAP (IFG cycles) → IDLE.
- dataOut per state (all outputs registered):
  - PRE: PREAMBLE.
  - HDR: {dst, src}.
  - LEN: {len zero-extended to 16 bits, 16'h0000}.
  - PAY: the FIFO head word.
  - FCS: the XOR of the HDR, LEN and every PAY word. PREAMBLE is excluded.
  - IDLE and GAP: 32'h0000_0000.
- FIFO underrun cannot occur, because acceptance guarantees the words are present. Pushes during a frame are allowed.
- Reset values:
  - dataOut = 0.
  - tx_sop, tx_eop, tx_busy, tx_err, cmd_ready = 0.
  - pl_ready = 1 once reset deasserts.
  - fifo_count = 0, FIFO pointers = 0, FSM = IDLE.
- Reset mid-frame: the frame is truncated and buffered words are discarded. dataOut returns to 0 asynchronously.

## Timing

- Command accepted on edge N:
  - PREAMBLE appears after edge N+1 (tx_sop high).
  - HDR after N+2, LEN after N+3.
  - Payload words after N+4 … N+3+len.
  - FCS after N+4+len (tx_eop high).
  - GAP for IFG cycles.
- Earliest next acceptance is at edge N+5+len+IFG. Frame period is 5+len+IFG cycles.
- FIFO write-to-count latency is one cycle. A word pushed on edge M counts toward cmd_ready from the cycle after M.
- tx_err is high for exactly the one cycle after the illegal handshake.
- cmd_ready is combinational from state, count and cmd_len. It never depends on cmd_valid.

## Test plan

- Reset: hold reset low for 3 cycles, then release -> all outputs at reset values; pl_ready=1 from the first cycle after release.
- Single frame: push 32'h1234_5678, then command dst=16'hAAAA, src=16'h0001, len=1 -> dataOut sequence 5555_55D5, AAAA_0001, 0001_0000, 1234_5678, B89F_5679, then 0 for 2 cycles; tx_sop and tx_eop on the first and fifth words.
- Back-to-back: push 8 words, then issue two len=4 commands with cmd_valid held -> second PREAMBLE exactly 11 cycles after the first; payload order preserved; each FCS matches the XOR model.
- Full FIFO: push 17 words with pl_valid held -> pl_ready drops after 16, fifo_count=16, and the 17th word is held off. Then send a len=16 frame -> simultaneous push/pop keeps count correct; pl_ready reasserts the cycle after the first pop.
- Illegal and insufficient commands:
  - len=0 -> accepted in IDLE, tx_err one-cycle pulse, no PREAMBLE, fifo_count unchanged.
  - len=3 with only 2 words buffered -> cmd_ready=0 until the third word arrives.
- Reset mid-frame: assert reset during PAY of a len=8 frame -> dataOut=0 immediately. After release, fifo_count=0 and the next legal frame transmits correctly.
